// File: rtl/background_writer_if.sv
// background_writer_if: stream pixel input and store-RAM write bus of the background writer.
interface background_writer_if #(
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 11
);
    logic              in_valid;
    logic [PIX_W-1:0]  in_pixel;
    logic              in_ready;
    logic              mem_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_data;
    modport master (
        input  in_valid, in_pixel, mem_busy,
        output in_ready, mem_we, mem_addr, mem_data
    );
    modport slave (
        output in_valid, in_pixel, mem_busy,
        input  in_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/background_writer.sv
// background_writer: fills the background pixel store in raster order from a pixel stream or a constant colour.
module background_writer #(
    parameter int COLS   = 64,
    parameter int ROWS   = 32,
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 11
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                mode,
    input  logic [PIX_W-1:0]    fill_color,
    input  logic                abort,
    background_writer_if.master bus,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     cells_written
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, FILL = 2'd2, DONE = 2'd3;
    logic [1:0]       state;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic             mode_q;
    logic [PIX_W-1:0] fill_q;
    logic             beat;
    logic             last;
    assign bus.in_ready = (state == STREAM) && !bus.mem_busy && !abort;
    assign beat = (bus.in_ready && bus.in_valid) || ((state == FILL) && !bus.mem_busy && !abort);
    // grid dimensions are powers of two, so all-ones marks the final column/row
    assign last = (&col) && (&row);
    assign busy = state != IDLE;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            col           <= '0;
            row           <= '0;
            mode_q        <= 1'b0;
            fill_q        <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_data  <= '0;
            done          <= 1'b0;
            cells_written <= '0;
        end else begin
            bus.mem_we <= beat;
            done       <= beat && last;
            if (beat) begin
                bus.mem_addr  <= ADDR_W'({row, col});
                bus.mem_data  <= mode_q ? fill_q : bus.in_pixel;
                cells_written <= cells_written + (ADDR_W+1)'(1);
                col           <= col + CW'(1);
                if (&col) row <= row + RW'(1);
            end
            if (state == IDLE && start && !abort) begin
                mode_q        <= mode;
                fill_q        <= fill_color;
                col           <= '0;
                row           <= '0;
                cells_written <= '0;
                state         <= mode ? FILL : STREAM;
            end else if (state == DONE || (state != IDLE && abort)) begin
                state <= IDLE;
            end else if (beat && last) begin
                state <= DONE;
            end
        end
    end
endmodule

// File: tb/tb_background_writer.sv
// tb_background_writer: directed tests of the background writer with hand-computed expectations.
module tb_background_writer;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] fill_color = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] cells_written;
    int          tests = 0;
    int          fails = 0;

    background_writer_if #(.PIX_W(12), .ADDR_W(11)) bus ();

    background_writer #(.COLS(64), .ROWS(32), .PIX_W(12), .ADDR_W(11)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
        .fill_color(fill_color), .abort(abort), .bus(bus),
        .busy(busy), .done(done), .cells_written(cells_written)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b1; bus.in_valid = 1'b1; bus.in_pixel = 12'h123;
        repeat (3) @(posedge clock);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
        tests++; if (bus.mem_addr !== 11'd0 || bus.mem_data !== 12'd0) begin fails++; $display("FAIL reset_bus: addr %h data %h want 0 0", bus.mem_addr, bus.mem_data); end
        tests++; if (cells_written !== 12'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", cells_written); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", bus.in_ready); end
        start = 1'b0; bus.in_valid = 1'b0; reset_n = 1'b1;
        tick();
        tests++; if (busy !== 1'b0 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_release: busy %b we %b want 0 0", busy, bus.mem_we); end
    endtask

    task automatic test_stream();
        int bad; int dones; int fk; logic [10:0] fa; logic [11:0] fd;
        bad = 0; dones = 0; fk = -1; fa = '0; fd = '0;
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0; bus.in_valid = 1'b1;
        for (int k = 0; k < 2048; k++) begin
            bus.in_pixel = 12'(k);
            #1;
            if (bus.in_ready !== 1'b1) bad++;
            tick();
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 11'(k) || bus.mem_data !== 12'(k) || cells_written !== 12'(k + 1)) begin
                if (fk < 0) begin fk = k; fa = bus.mem_addr; fd = bus.mem_data; end
                bad++;
            end
            if (done === 1'b1) dones++;
        end
        bus.in_valid = 1'b0;
        tests++; if (bad !== 0) begin fails++; $display("FAIL stream_seq: %0d bad beats, first k=%0d addr %0d data %h want addr=data=k", bad, fk, fa, fd); end
        tests++; if (done !== 1'b1 || busy !== 1'b1 || bus.mem_addr !== 11'd2047) begin fails++; $display("FAIL stream_done: done %b busy %b addr %0d want 1 1 2047", done, busy, bus.mem_addr); end
        tick();
        tests++; if (busy !== 1'b0 || done !== 1'b0 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL stream_end: busy %b done %b we %b want 0 0 0", busy, done, bus.mem_we); end
        tests++; if (cells_written !== 12'd2048) begin fails++; $display("FAIL stream_count: got %0d want 2048", cells_written); end
        tests++; if (dones !== 1) begin fails++; $display("FAIL stream_done_once: got %0d pulses want 1", dones); end
    endtask

    task automatic test_fill();
        int bad; int dones; int fi; logic [10:0] fa; logic [11:0] fd;
        bad = 0; dones = 0; fi = -1; fa = '0; fd = '0;
        start = 1'b1; mode = 1'b1; fill_color = 12'h7cf;
        tick();
        start = 1'b0; fill_color = 12'h000;
        tests++; if (bus.mem_we !== 1'b0) begin fails++; $display("FAIL fill_first_we: got %b one cycle after start want 0", bus.mem_we); end
        for (int i = 0; i < 2048; i++) begin
            tick();
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 11'(i) || bus.mem_data !== 12'h7cf) begin
                if (fi < 0) begin fi = i; fa = bus.mem_addr; fd = bus.mem_data; end
                bad++;
            end
            if (done === 1'b1) dones++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL fill_seq: %0d bad writes, first i=%0d addr %0d data %h want addr=i data=7cf", bad, fi, fa, fd); end
        tests++; if (done !== 1'b1 || dones !== 1) begin fails++; $display("FAIL fill_done: done %b pulses %0d want 1 1", done, dones); end
        tick();
        tests++; if (busy !== 1'b0 || cells_written !== 12'd2048) begin fails++; $display("FAIL fill_end: busy %b count %0d want 0 2048", busy, cells_written); end
    endtask

    task automatic test_stall_wrap();
        int bad; int stall_bad;
        bad = 0; stall_bad = 0;
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0; bus.in_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            bus.in_pixel = 12'(k);
            tick();
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 11'(k) || bus.mem_data !== 12'(k)) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL wrap_row0: %0d bad beats want 0", bad); end
        bus.mem_busy = 1'b1; bus.in_pixel = 12'd64;
        for (int s = 0; s < 3; s++) begin
            #1;
            if (bus.in_ready !== 1'b0) stall_bad++;
            tick();
            if (bus.mem_we !== 1'b0) stall_bad++;
        end
        tests++; if (stall_bad !== 0) begin fails++; $display("FAIL stall_hold: %0d ready/we violations want 0", stall_bad); end
        tests++; if (cells_written !== 12'd64) begin fails++; $display("FAIL stall_count: got %0d want 64", cells_written); end
        bus.mem_busy = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL stall_release_ready: got %b want 1", bus.in_ready); end
        tick();
        tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 11'd64 || bus.mem_data !== 12'd64) begin fails++; $display("FAIL wrap_row1: we %b addr %0d data %0d want 1 64 64", bus.mem_we, bus.mem_addr, bus.mem_data); end
        tests++; if (cells_written !== 12'd65) begin fails++; $display("FAIL wrap_count: got %0d want 65", cells_written); end
        start = 1'b1; mode = 1'b1; fill_color = 12'hfff; bus.in_pixel = 12'd65;
        tick();
        start = 1'b0;
        tests++; if (busy !== 1'b1 || bus.mem_addr !== 11'd65 || bus.mem_data !== 12'd65) begin fails++; $display("FAIL start_mid_stream: busy %b addr %0d data %h want 1 65 041", busy, bus.mem_addr, bus.mem_data); end
        abort = 1'b1; bus.in_pixel = 12'd66;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b want 0", bus.in_ready); end
        tick();
        abort = 1'b0; bus.in_valid = 1'b0;
        tests++; if (busy !== 1'b0 || bus.mem_we !== 1'b0 || done !== 1'b0 || cells_written !== 12'd66) begin fails++; $display("FAIL stream_abort: busy %b we %b done %b count %0d want 0 0 0 66", busy, bus.mem_we, done, cells_written); end
    endtask

    task automatic test_abort();
        int bad; int dones;
        bad = 0; dones = 0;
        start = 1'b1; mode = 1'b1; fill_color = 12'h7cf;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== 11'(i) || bus.mem_data !== 12'h7cf) bad++;
            if (done === 1'b1) dones++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL abort_writes: %0d bad writes want 0", bad); end
        abort = 1'b1;
        tests++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 11'd99) begin fails++; $display("FAIL abort_inflight: we %b addr %0d want 1 99", bus.mem_we, bus.mem_addr); end
        tick();
        abort = 1'b0;
        tests++; if (busy !== 1'b0 || bus.mem_we !== 1'b0 || done !== 1'b0 || dones !== 0) begin fails++; $display("FAIL abort_idle: busy %b we %b done %b pulses %0d want 0 0 0 0", busy, bus.mem_we, done, dones); end
        tests++; if (cells_written !== 12'd100) begin fails++; $display("FAIL abort_count: got %0d want 100", cells_written); end
        tick();
        tests++; if (bus.mem_we !== 1'b0 || cells_written !== 12'd100) begin fails++; $display("FAIL abort_after: we %b count %0d want 0 100", bus.mem_we, cells_written); end
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0; abort = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL start_abort_idle: busy %b want 0", busy); end
        tick();
        tests++; if (busy !== 1'b0 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL start_abort_after: busy %b we %b want 0 0", busy, bus.mem_we); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; mode = 1'b1; fill_color = 12'h0a5;
        tick();
        start = 1'b0;
        repeat (5) tick();
        tests++; if (busy !== 1'b1 || cells_written !== 12'd5) begin fails++; $display("FAIL reset_mid_pre: busy %b count %0d want 1 5", busy, cells_written); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tests++; if (busy !== 1'b0 || bus.mem_we !== 1'b0 || done !== 1'b0 || cells_written !== 12'd0) begin fails++; $display("FAIL reset_mid: busy %b we %b done %b count %0d want 0 0 0 0", busy, bus.mem_we, done, cells_written); end
        tick();
        tests++; if (busy !== 1'b0 || bus.mem_we !== 1'b0) begin fails++; $display("FAIL reset_mid_after: busy %b we %b want 0 0", busy, bus.mem_we); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_pixel = '0;
        bus.mem_busy = 1'b0;
        test_reset();
        test_stream();
        test_fill();
        test_stall_wrap();
        test_abort();
        test_start_abort_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
